// File: rtl/jtsdram_bank_rd.sv
// Per-bank SDRAM read tester: walks an LFSR address sequence on a read-only bank port and
// compares each returned 32-bit word pair against the address-derived download pattern.
module jtsdram_bank_rd #(
  parameter logic [20:0] SEED = 21'h1ACE5,
  parameter logic [7:0]  TOUT = 8'd200,
  parameter logic [15:0] NRD  = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clr,
  output logic [21:0] ba_addr,
  output logic        ba_rd,
  input  logic        ba_ack,
  input  logic        ba_rdy,
  input  logic [31:0] data_read,
  output logic        busy,
  output logic        done,
  output logic        bad,
  output logic        timeout,
  output logic [15:0] rd_cnt
);

  // state  | meaning
  // IDLE   | waiting for enable
  // REQ    | ba_rd high, waiting for ack
  // WAIT   | request accepted, waiting for rdy or timer terminal count
  // CHECK  | compare registered data with expected pattern
  // NEXT   | advance LFSR, decide done / continue / stop
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CHECK, S_NEXT} state_t;

  state_t      state_q, state_d;
  logic [20:0] lfsr_q, lfsr_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  timer_q, timer_d;
  logic        pend_q, pend_d;
  logic [31:0] data_q, data_d;
  logic        bad_q, bad_d;
  logic        timeout_q, timeout_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic        done_q, done_d;

  logic [21:0] addr_p1;
  logic [31:0] expected;

  function automatic logic [15:0] pat(input logic [21:0] a);
    return {a[7:0], a[15:8]} ^ {10'd0, a[21:16]};
  endfunction

  assign addr_p1  = addr_q + 22'd1;
  assign expected = {pat(addr_p1), pat(addr_q)};

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    addr_d    = addr_q;
    timer_d   = timer_q;
    pend_d    = pend_q;
    data_d    = data_q;
    bad_d     = bad_q;
    timeout_d = timeout_q;
    rd_cnt_d  = rd_cnt_q;
    done_d    = 1'b0;
    if (clr) begin
      state_d   = S_IDLE;
      lfsr_d    = SEED;
      bad_d     = 1'b0;
      timeout_d = 1'b0;
      rd_cnt_d  = 16'd0;
      pend_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (enable) state_d = S_REQ;
        S_REQ: begin
          if (ba_ack) begin
            state_d = S_WAIT;
            timer_d = TOUT - 8'd1;
            // rdy coinciding with ack is kept and consumed on the first WAIT cycle
            pend_d  = ba_rdy;
            if (ba_rdy) data_d = data_read;
          end
        end
        S_WAIT: begin
          if (pend_q || ba_rdy) begin
            state_d = S_CHECK;
            pend_d  = 1'b0;
            if (!pend_q) data_d = data_read;
          end else if (timer_q == 8'd0) begin
            state_d   = S_NEXT;
            bad_d     = 1'b1;
            timeout_d = 1'b1;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        S_CHECK: begin
          state_d  = S_NEXT;
          rd_cnt_d = rd_cnt_q + 16'd1;
          if (data_q != expected) begin
            bad_d     = 1'b1;
            timeout_d = 1'b0;
          end
        end
        S_NEXT: begin
          lfsr_d = {lfsr_q[19:0], lfsr_q[20] ^ lfsr_q[18]};
          if (NRD != 16'd0 && rd_cnt_q == NRD) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = enable ? S_REQ : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // address is latched on REQ entry so it stays stable for the whole transaction
    if (state_d == S_REQ && state_q != S_REQ) addr_d = {lfsr_d, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      addr_q    <= 22'd0;
      timer_q   <= 8'd0;
      pend_q    <= 1'b0;
      data_q    <= 32'd0;
      bad_q     <= 1'b0;
      timeout_q <= 1'b0;
      rd_cnt_q  <= 16'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      addr_q    <= addr_d;
      timer_q   <= timer_d;
      pend_q    <= pend_d;
      data_q    <= data_d;
      bad_q     <= bad_d;
      timeout_q <= timeout_d;
      rd_cnt_q  <= rd_cnt_d;
      done_q    <= done_d;
    end
  end

  assign ba_rd   = (state_q == S_REQ);
  assign ba_addr = addr_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign bad     = bad_q;
  assign timeout = timeout_q;
  assign rd_cnt  = rd_cnt_q;

endmodule

// File: tb/tb_jtsdram_bank_rd.sv
// Directed bench for jtsdram_bank_rd: acts as the SDRAM bank port and checks addresses and flags.
module tb_jtsdram_bank_rd;
  localparam logic [20:0] SEED = 21'h1ACE5;
  localparam logic [7:0]  TOUT = 8'd200;
  localparam logic [15:0] NRD  = 16'd4;

  logic        clk = 1'b0;
  logic        rst_n, enable, clr, ba_ack, ba_rdy;
  logic [31:0] data_read;
  logic [21:0] ba_addr;
  logic        ba_rd, busy, done, bad, timeout;
  logic [15:0] rd_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  logic [20:0] exp_lfsr;

  jtsdram_bank_rd #(.SEED(SEED), .TOUT(TOUT), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
    .data_read(data_read), .busy(busy), .done(done), .bad(bad),
    .timeout(timeout), .rd_cnt(rd_cnt)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [15:0] pat(input logic [21:0] a);
    return {a[7:0], a[15:8]} ^ {10'd0, a[21:16]};
  endfunction

  function automatic logic [31:0] exp_data(input logic [20:0] l);
    logic [21:0] a;
    a = {l, 1'b0};
    return {pat(a + 22'd1), pat(a)};
  endfunction

  function automatic logic [20:0] lfsr_step(input logic [20:0] s);
    return {s[19:0], s[20] ^ s[18]};
  endfunction

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_lfsr = SEED;
  endtask

  // Serves one read; returns on the negedge where the DUT sits in NEXT.
  task automatic serve(input int ack_dly, input int rdy_dly, input logic [31:0] mask,
                       input bit same, input string tag);
    int n = 0;
    while (ba_rd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (ba_rd !== 1'b1) begin
      miscompares++; $display("FAIL %s_rd: ba_rd=%b want 1", tag, ba_rd);
    end
    repeat (ack_dly) @(negedge clk);
    vectors++;
    if (ba_addr !== {exp_lfsr, 1'b0} || ba_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_addr: addr=%h rd=%b want addr=%h rd=1", tag, ba_addr, ba_rd, {exp_lfsr, 1'b0});
    end
    ba_ack = 1'b1;
    if (same) begin
      ba_rdy = 1'b1; data_read = exp_data(exp_lfsr) ^ mask;
    end
    @(negedge clk);
    ba_ack = 1'b0; ba_rdy = 1'b0;
    vectors++;
    if (ba_rd !== 1'b0) begin
      miscompares++; $display("FAIL %s_rd_drop: ba_rd=%b want 0", tag, ba_rd);
    end
    if (same) begin
      repeat (2) @(negedge clk);
    end else begin
      repeat (rdy_dly - 1) @(negedge clk);
      ba_rdy = 1'b1; data_read = exp_data(exp_lfsr) ^ mask;
      @(negedge clk);
      ba_rdy = 1'b0;
      @(negedge clk);
    end
    exp_lfsr = lfsr_step(exp_lfsr);
  endtask

  task automatic test_reset();
    #25;
    vectors++;
    if (ba_rd !== 0 || ba_addr !== 22'd0 || busy !== 0 || done !== 0 || bad !== 0 ||
        timeout !== 0 || rd_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset: rd=%b addr=%h busy=%b done=%b bad=%b to=%b cnt=%0d want all 0",
               ba_rd, ba_addr, busy, done, bad, timeout, rd_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_lfsr = SEED;
    @(negedge clk);
    vectors++;
    if (busy !== 0 || ba_rd !== 0) begin
      miscompares++; $display("FAIL reset_idle: busy=%b rd=%b want 0 0", busy, ba_rd);
    end
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    enable = 1'b1;
    @(negedge clk);
    vectors++;
    if (ba_rd !== 1'b1) begin
      miscompares++; $display("FAIL basic_latency: ba_rd=%b want 1", ba_rd);
    end
    for (int i = 1; i <= 4; i++) begin
      serve(2, 6, 32'd0, 1'b0, "basic");
      vectors++;
      if (rd_cnt !== 16'(i) || bad !== 1'b0) begin
        miscompares++; $display("FAIL basic_cnt: cnt=%0d bad=%b want %0d 0", rd_cnt, bad, i);
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_done: done=%b busy=%b want 1 0", done, busy);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt - d0 !== 1 || rd_cnt !== 16'd4 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_end: pulses=%0d cnt=%0d busy=%b want 1 4 0", done_cnt - d0, rd_cnt, busy);
    end
  endtask

  task automatic test_corrupt();
    int d0 = done_cnt;
    pulse_clr();
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      serve(2, 6, (i == 3) ? 32'h0002_0000 : 32'd0, 1'b0, "corrupt");
      vectors++;
      if (bad !== (i >= 3) || timeout !== 1'b0 || rd_cnt !== 16'(i)) begin
        miscompares++;
        $display("FAIL corrupt_flags: read=%0d bad=%b to=%b cnt=%0d want %b 0 %0d",
                 i, bad, timeout, rd_cnt, (i >= 3), i);
      end
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL corrupt_done: pulses=%0d busy=%b want 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    pulse_clr();
    enable = 1'b1;
    while (ba_rd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (ba_rd !== 1'b1 || ba_addr !== {SEED, 1'b0}) begin
      miscompares++; $display("FAIL tout_req: rd=%b addr=%h want 1 %h", ba_rd, ba_addr, {SEED, 1'b0});
    end
    ba_ack = 1'b1;
    @(negedge clk);
    ba_ack = 1'b0;
    repeat (int'(TOUT) - 1) @(negedge clk);
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++; $display("FAIL tout_early: bad=%b want 0", bad);
    end
    @(negedge clk);
    vectors++;
    if (bad !== 1'b1 || timeout !== 1'b1 || rd_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL tout_flag: bad=%b to=%b cnt=%0d want 1 1 0", bad, timeout, rd_cnt);
    end
    enable = 1'b0;
    @(negedge clk);
    ba_rdy = 1'b1; data_read = 32'hDEAD_BEEF;
    @(negedge clk);
    ba_rdy = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rd_cnt !== 16'd0 || bad !== 1'b1 || timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL tout_idle_rdy: busy=%b cnt=%0d bad=%b to=%b want 0 0 1 1", busy, rd_cnt, bad, timeout);
    end
  endtask

  task automatic test_same_cycle();
    pulse_clr();
    vectors++;
    if (bad !== 1'b0 || timeout !== 1'b0) begin
      miscompares++; $display("FAIL same_clr: bad=%b to=%b want 0 0", bad, timeout);
    end
    enable = 1'b1;
    serve(1, 0, 32'd0, 1'b1, "same1");
    vectors++;
    if (bad !== 1'b0 || rd_cnt !== 16'd1) begin
      miscompares++; $display("FAIL same_good: bad=%b cnt=%0d want 0 1", bad, rd_cnt);
    end
    serve(1, 0, 32'h0000_0001, 1'b1, "same2");
    vectors++;
    if (bad !== 1'b1 || timeout !== 1'b0 || rd_cnt !== 16'd2) begin
      miscompares++; $display("FAIL same_bad: bad=%b to=%b cnt=%0d want 1 0 2", bad, timeout, rd_cnt);
    end
    serve(2, 3, 32'd0, 1'b0, "same3");
    vectors++;
    if (rd_cnt !== 16'd3) begin
      miscompares++; $display("FAIL same_follow: cnt=%0d want 3", rd_cnt);
    end
    enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL same_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    pulse_clr();
    enable = 1'b1;
    while (ba_rd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    ba_ack = 1'b1;
    @(negedge clk);
    ba_ack = 1'b0; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (ba_rd !== 1'b0 || busy !== 1'b1) begin
        miscompares++; $display("FAIL drop_wait: rd=%b busy=%b want 0 1", ba_rd, busy);
      end
    end
    ba_rdy = 1'b1; data_read = exp_data(SEED) ^ 32'h8000_0000;
    @(negedge clk);
    ba_rdy = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ba_rd !== 1'b0 || rd_cnt !== 16'd1 || bad !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_idle: busy=%b rd=%b cnt=%0d bad=%b want 0 0 1 1", busy, ba_rd, rd_cnt, bad);
    end
    pulse_clr();
    vectors++;
    if (rd_cnt !== 16'd0 || bad !== 1'b0 || timeout !== 1'b0) begin
      miscompares++; $display("FAIL drop_clr: cnt=%0d bad=%b to=%b want 0 0 0", rd_cnt, bad, timeout);
    end
    enable = 1'b1;
    @(negedge clk);
    vectors++;
    if (ba_rd !== 1'b1 || ba_addr !== {SEED, 1'b0}) begin
      miscompares++; $display("FAIL drop_reseed: rd=%b addr=%h want 1 %h", ba_rd, ba_addr, {SEED, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ba_rd !== 0 || ba_addr !== 22'd0 || busy !== 0 || done !== 0 || bad !== 0 ||
        timeout !== 0 || rd_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_async: rd=%b addr=%h busy=%b done=%b bad=%b to=%b cnt=%0d want all 0",
               ba_rd, ba_addr, busy, done, bad, timeout, rd_cnt);
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ba_rdy = 1'b1; data_read = 32'h1234_5678;
    @(negedge clk);
    ba_rdy = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ba_rd !== 1'b0 || rd_cnt !== 16'd0 || bad !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rdy_ignored: busy=%b rd=%b cnt=%0d bad=%b want 0 0 0 0", busy, ba_rd, rd_cnt, bad);
    end
    enable = 1'b1;
    @(negedge clk);
    vectors++;
    if (ba_rd !== 1'b1 || ba_addr !== {SEED, 1'b0}) begin
      miscompares++; $display("FAIL rst_reseed: rd=%b addr=%h want 1 %h", ba_rd, ba_addr, {SEED, 1'b0});
    end
    enable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clr = 1'b0;
    ba_ack = 1'b0; ba_rdy = 1'b0; data_read = 32'd0;
    exp_lfsr = SEED;
    test_reset();
    test_basic();
    test_corrupt();
    test_timeout();
    test_same_cycle();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
